uart_byte_rx: RTL

//   Asynchronous serial receiver: 8N1 framing, LSB first, line idle high.

---
 rtl/uart_byte_rx.sv | 80 ++++++++
 1 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial receiver (LSB first, idle high) with framing-error detection
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  output logic [WIDTH-1:0] rx_byte,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [WIDTH-1:0] sh, sh_n, byte_n;
  logic valid_n, err_n;
  logic [1:0] sync;
  logic rxd_s;
  assign rxd_s = sync[1];
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      rx_byte <= byte_n;
      rx_valid <= valid_n;
      frame_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    sh_n = sh;
    byte_n = rx_byte;
    valid_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: state_n = rxd_s ? IDLE : START;
      START: begin
        state_n = (cnt == HALF_M1) ? (rxd_s ? IDLE : DATA) : START;
        idx_n = '0;
      end
      DATA: if (cnt == BIT_M1) begin
        sh_n = {rxd_s, sh[WIDTH-1:1]};
        idx_n = idx + 1'b1;
        state_n = (idx == LAST) ? STOP : DATA;
      end
      STOP: if (cnt == BIT_M1) begin
        byte_n = rxd_s ? sh : rx_byte;
        valid_n = rxd_s;
        err_n = !rxd_s;
        state_n = rxd_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: state_n = rxd_s ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
    // counter restarts on every state entry and at each bit boundary
    cnt_n = (state_n != state || cnt == BIT_M1 || state == IDLE || state == WAIT_IDLE) ? '0 : cnt + 1'b1;
  end
endmodule
